// File: rtl/sdram_uart_write_packer.sv
// sdram_uart_write_packer
// Packs UART byte pairs into 16-bit words, buffers them in a small FIFO and
// feeds the SDRAM controller's host write port, filling a linear frame region
// that wraps back to BASE_ADDR after FRAME_WORDS words.
module sdram_uart_write_packer #(
    parameter int HADDR_WIDTH = 22,
    parameter int BASE_ADDR   = 0,
    parameter int FRAME_WORDS = 76800,
    parameter int FIFO_DEPTH  = 4      // power of two, at least 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    input  logic                          frame_start,
    output logic [HADDR_WIDTH-1:0]        wr_addr,
    output logic [15:0]                   wr_data,
    output logic                          wr_enable,
    input  logic                          wr_addr_inc,
    input  logic                          busy,
    output logic                          frame_done,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(FRAME_WORDS + 1);

    localparam logic [HADDR_WIDTH-1:0] BASE     = HADDR_WIDTH'(BASE_ADDR);
    localparam logic [CW-1:0]          LAST_CNT = CW'(FRAME_WORDS - 1);
    localparam logic [LW-1:0]          FULL_LVL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_GAP  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   phase_q, phase_d;        // 1: low byte held
    logic [7:0]             low_byte_q, low_byte_d;
    logic [15:0]            mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic [HADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]            data_q, data_d;
    logic                   en_q, en_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic                   ovf_q, ovf_d;

    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic [15:0]            push_word;

    assign fifo_full = (level_q == FULL_LVL);
    assign push_word = {rx_data, low_byte_q};

    // Next-state logic: packing, FIFO bookkeeping and the write-handshake FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d    = state_q;
        phase_d    = phase_q;
        low_byte_d = low_byte_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        addr_d     = addr_q;
        data_d     = data_q;
        en_d       = en_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        push       = 1'b0;
        pop        = 1'b0;

        if (frame_start) begin
            // Frame restart wins over everything, including a same-cycle byte.
            state_d  = W_IDLE;
            phase_d  = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            addr_d   = BASE;
            en_d     = 1'b0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            if (rx_valid) begin
                phase_d = ~phase_q;
                if (!phase_q) begin
                    low_byte_d = rx_data;
                end
            end

            case (state_q)
                W_IDLE: begin
                    if ((level_q != '0) && !busy) begin
                        pop     = 1'b1;
                        data_d  = mem_q[rd_ptr_q];
                        en_d    = 1'b1;
                        state_d = W_REQ;
                    end
                end
                W_REQ: begin
                    // Address and data stay frozen until the controller acks.
                    if (wr_addr_inc) begin
                        en_d    = 1'b0;
                        done_d  = (cnt_q == LAST_CNT);
                        state_d = W_GAP;
                    end
                end
                W_GAP: begin
                    if (cnt_q == LAST_CNT) begin
                        addr_d = BASE;
                        cnt_d  = '0;
                    end else begin
                        addr_d = addr_q + HADDR_WIDTH'(1);
                        cnt_d  = cnt_q + CW'(1);
                    end
                    state_d = W_IDLE;
                end
                default: begin
                    state_d = W_IDLE;
                end
            endcase

            // A full FIFO still accepts the word if the head leaves this cycle.
            if (rx_valid && phase_q) begin
                if (!fifo_full || pop) begin
                    push = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end

            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            state_q    <= W_IDLE;
            phase_q    <= 1'b0;
            low_byte_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            addr_q     <= BASE;
            data_q     <= '0;
            en_q       <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            low_byte_q <= low_byte_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            en_q       <= en_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; the pointers and level define validity.
        if (push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign wr_addr    = addr_q;
    assign wr_data    = data_q;
    assign wr_enable  = en_q;
    assign frame_done = done_q;
    assign overflow   = ovf_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_sdram_uart_write_packer.sv
// Testbench for sdram_uart_write_packer: directed scenarios plus a randomized
// run, checked by a scoreboard fed from a word-level reference model.
`timescale 1ns/1ps
module tb_sdram_uart_write_packer;

    localparam int HADDR_WIDTH = 22;
    localparam int BASE_ADDR   = 'h40;
    localparam int FRAME_WORDS = 4;
    localparam int FIFO_DEPTH  = 4;
    localparam int LW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [HADDR_WIDTH-1:0] BASE = HADDR_WIDTH'(BASE_ADDR);

    typedef struct {
        logic [HADDR_WIDTH-1:0] addr;
        logic [15:0]            data;
        bit                     last;
    } exp_t;

    logic                   clk;
    logic                   rst_n;
    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic                   frame_start;
    logic [HADDR_WIDTH-1:0] wr_addr;
    logic [15:0]            wr_data;
    logic                   wr_enable;
    logic                   wr_addr_inc;
    logic                   busy;
    logic                   frame_done;
    logic                   overflow;
    logic [LW-1:0]          fifo_level;

    // Bench state
    exp_t  sb_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    n_done   = 0;
    bit    m_phase;
    logic [7:0] m_low;
    int    m_k;
    bit    ctl_hold   = 0;
    bit    ctl_ack    = 0;
    bit    man_ack    = 0;
    int    ctl_min    = 1;
    int    ctl_max    = 1;
    bit    busy_force = 0;
    bit    busy_rand  = 0;

    assign wr_addr_inc = ctl_ack | man_ack;

    sdram_uart_write_packer #(
        .HADDR_WIDTH (HADDR_WIDTH),
        .BASE_ADDR   (BASE_ADDR),
        .FRAME_WORDS (FRAME_WORDS),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_start (frame_start),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_enable   (wr_enable),
        .wr_addr_inc (wr_addr_inc),
        .busy        (busy),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .fifo_level  (fifo_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: pairs bytes into words; each accepted word is written
    // at BASE + (index within frame). In-flight words (accepted, not yet acked)
    // never exceed the FIFO depth plus nothing held in the scenarios that can
    // fill it, so the queue size stands in for occupancy.
    task automatic model_clear();
        sb_q.delete();
        m_phase = 0;
        m_low   = '0;
        m_k     = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        exp_t e;
        if (!m_phase) begin
            m_low   = b;
            m_phase = 1;
        end else begin
            m_phase = 0;
            if (sb_q.size() < FIFO_DEPTH) begin
                e.addr = HADDR_WIDTH'(BASE_ADDR + (m_k % FRAME_WORDS));
                e.data = {b, m_low};
                e.last = ((m_k % FRAME_WORDS) == FRAME_WORDS - 1);
                sb_q.push_back(e);
                m_k++;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        model_byte(b);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_pair(input logic [15:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
    endtask

    task automatic gate_in_flight();
        int n = 0;
        while (sb_q.size() >= FIFO_DEPTH && n < 500) begin
            tick();
            n++;
        end
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        model_clear();
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_enable(input string name);
        int n = 0;
        while (!wr_enable && n < 200) begin
            tick();
            n++;
        end
        check(name, 32'(wr_enable), 32'd1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((sb_q.size() != 0 || wr_enable) && n < 3000) begin
            tick();
            n++;
        end
        check(name, 32'(sb_q.size()), 32'd0);
        repeat (3) tick();
    endtask

    // Controller model: acknowledges a held request after a random latency.
    initial begin
        int held;
        int delay;
        held  = 0;
        delay = 1;
        forever begin
            @(posedge clk);
            #1;
            ctl_ack = 1'b0;
            if (wr_enable && !ctl_hold) begin
                held++;
                if (held == 1) begin
                    delay = $urandom_range(ctl_max, ctl_min);
                end
                if (held >= delay) begin
                    ctl_ack = 1'b1;
                    held    = 0;
                end
            end else begin
                held = 0;
            end
        end
    end

    // Busy driver: forced level or random refresh/access activity.
    initial begin
        busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            busy = busy_rand ? ($urandom_range(0, 3) == 0) : busy_force;
        end
    end

    // Monitor: pops the scoreboard on every accepted write and checks the
    // handshake rules, sampling on the falling edge.
    exp_t                   mon_e;
    bit                     prev_en   = 0;
    bit                     prev_busy = 0;
    bit                     done_next = 0;
    int                     since_ack = 100;
    logic [HADDR_WIDTH-1:0] held_addr;
    logic [15:0]            held_data;

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_done || done_next) begin
                check("frame_done", 32'(frame_done), 32'(done_next));
            end
            if (frame_done) begin
                n_done++;
            end
            done_next = 0;
            since_ack++;

            if (wr_enable && !prev_en) begin
                check("req_while_busy", 32'(prev_busy), 32'd0);
                check("ack_to_req_gap", 32'(since_ack >= 3), 32'd1);
                held_addr = wr_addr;
                held_data = wr_data;
            end else if (wr_enable && prev_en) begin
                check("hold_addr", 32'(wr_addr), 32'(held_addr));
                check("hold_data", 32'(wr_data), 32'(held_data));
            end

            if (wr_enable && wr_addr_inc) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_write", 32'(wr_data), 32'hFFFF_FFFF);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("write_addr", 32'(wr_addr), 32'(mon_e.addr));
                    check("write_data", 32'(wr_data), 32'(mon_e.data));
                    done_next = mon_e.last;
                end
                since_ack = 0;
            end
            prev_en   = wr_enable;
            prev_busy = busy;
        end
    end

    initial begin
        int done_base;
        rst_n       = 1'b0;
        rx_data     = '0;
        rx_valid    = 1'b0;
        frame_start = 1'b0;
        model_clear();

        // Reset values
        repeat (3) tick();
        check("rst_wr_addr",    32'(wr_addr),    32'(BASE));
        check("rst_wr_data",    32'(wr_data),    32'd0);
        check("rst_wr_enable",  32'(wr_enable),  32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overflow",   32'(overflow),   32'd0);
        check("rst_fifo_level", 32'(fifo_level), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single word, ack after 6 cycles
        ctl_min = 6;
        ctl_max = 6;
        send_byte(8'h34);
        send_byte(8'h12);
        wait_enable("t1_enable");
        check("t1_addr", 32'(wr_addr), 32'(BASE));
        check("t1_data", 32'(wr_data), 32'h1234);
        drain("t1_drain");
        check("t1_enable_low", 32'(wr_enable),  32'd0);
        check("t1_level",      32'(fifo_level), 32'd0);

        // Busy blocks requests; FIFO fills to 4
        ctl_min = 1;
        ctl_max = 4;
        pulse_frame_start();
        busy_force = 1;
        repeat (2) tick();
        for (int i = 0; i < 4; i++) send_pair(16'($urandom));
        repeat (3) tick();
        check("t2_no_enable", 32'(wr_enable),  32'd0);
        check("t2_level",     32'(fifo_level), 32'd4);
        busy_force = 0;
        drain("t2_drain");

        // Overflow: fifth word lost while full and busy
        pulse_frame_start();
        busy_force = 1;
        repeat (2) tick();
        for (int i = 0; i < 5; i++) send_pair(16'hA000 + 16'(i));
        tick();
        check("t3_overflow", 32'(overflow),   32'd1);
        check("t3_level",    32'(fifo_level), 32'd4);
        busy_force = 0;
        drain("t3_drain");
        check("t3_overflow_sticky", 32'(overflow), 32'd1);
        pulse_frame_start();
        check("t3_overflow_clr", 32'(overflow), 32'd0);

        // Frame wrap: five words, one frame_done, fifth at BASE
        ctl_min = 1;
        ctl_max = 3;
        done_base = n_done;
        for (int i = 0; i < 5; i++) begin
            gate_in_flight();
            send_pair(16'($urandom));
        end
        drain("t4_drain");
        check("t4_done_count", 32'(n_done - done_base), 32'd1);

        // Controller ignores the request for 20 cycles
        pulse_frame_start();
        ctl_min = 21;
        ctl_max = 21;
        send_pair(16'hBEEF);
        wait_enable("t5_enable");
        drain("t5_drain");

        // Odd byte, frame_start with a concurrent byte, then a clean pair
        ctl_min = 1;
        ctl_max = 3;
        pulse_frame_start();
        send_byte(8'h11);
        frame_start = 1'b1;
        rx_valid    = 1'b1;
        rx_data     = 8'h22;
        model_clear();
        tick();
        frame_start = 1'b0;
        rx_valid    = 1'b0;
        check("t6_level", 32'(fifo_level), 32'd0);
        send_byte(8'hCD);
        send_byte(8'hAB);
        drain("t6_drain");

        // frame_start during a held request, then a late ack
        ctl_hold = 1;
        pulse_frame_start();
        send_pair(16'h5A5A);
        wait_enable("t7_enable");
        pulse_frame_start();
        check("t7_enable_drop", 32'(wr_enable),  32'd0);
        check("t7_level",       32'(fifo_level), 32'd0);
        man_ack = 1'b1;
        tick();
        man_ack  = 1'b0;
        ctl_hold = 0;
        send_pair(16'h0F0F);
        drain("t7_drain");

        // Randomized traffic with random busy and ack latency
        pulse_frame_start();
        busy_rand = 1;
        ctl_min   = 1;
        ctl_max   = 8;
        for (int i = 0; i < 40; i++) begin
            gate_in_flight();
            send_byte(8'($urandom));
            repeat ($urandom_range(0, 3)) tick();
            send_byte(8'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end
        drain("rand_drain");
        busy_rand = 0;
        tick();
        check("rand_no_overflow", 32'(overflow), 32'd0);

        // Asynchronous reset in the middle of a request
        ctl_hold = 1;
        send_pair(16'h7777);
        wait_enable("rst_req_enable");
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_enable", 32'(wr_enable),  32'd0);
        check("arst_addr",   32'(wr_addr),    32'(BASE));
        check("arst_data",   32'(wr_data),    32'd0);
        check("arst_level",  32'(fifo_level), 32'd0);
        model_clear();
        done_next = 0;
        tick();
        rst_n    = 1'b1;
        ctl_hold = 0;
        tick();
        send_pair(16'hC0DE);
        drain("arst_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
